// File: rtl/clkdiv_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
// Optional build macro CLKDIV_GLITCHLESS_UPDATE_EN is interpreted in clkdiv_channel.
package clkdiv_pkg;

  localparam int CLKDIV_CNT_W_DEF = 32;
  localparam int CLKDIV_NCH_DEF   = 4;

  typedef logic [CLKDIV_CNT_W_DEF-1:0] cnt_t;

  // LSB position of channel k's divisor inside the packed div_i bus.
  function automatic int div_lsb(input int k, input int cnt_w);
    return k * cnt_w;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, divisor shadow, slow_clock and tick, all registered.
// Macro CLKDIV_GLITCHLESS_UPDATE_EN: divisor sampled only at period start (shadow register).
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int CNT_W = CLKDIV_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             slow_clock,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d, eff;
  logic             slow_q, slow_d;
  logic             tick_q, tick_d;
`ifdef CLKDIV_GLITCHLESS_UPDATE_EN
  logic [CNT_W-1:0] shadow_q, shadow_d;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    slow_d = slow_q;
    tick_d = 1'b0;
`ifdef CLKDIV_GLITCHLESS_UPDATE_EN
    shadow_d = shadow_q;
    eff      = (cnt_q == '0) ? div_i : shadow_q;
`else
    eff      = div_i;
`endif
    if (sync_i) begin
      cnt_d  = '0;
      slow_d = 1'b0;
    end else if (en_i) begin
      if (cnt_q == '0) begin
        slow_d = ~slow_q;
        tick_d = 1'b1;
`ifdef CLKDIV_GLITCHLESS_UPDATE_EN
        shadow_d = div_i;
`endif
      end
      // Terminal count wraps cleanly even for the all-ones divisor.
      cnt_d = (cnt_q == eff) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      slow_q <= 1'b0;
      tick_q <= 1'b0;
`ifdef CLKDIV_GLITCHLESS_UPDATE_EN
      shadow_q <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      slow_q <= slow_d;
      tick_q <= tick_d;
`ifdef CLKDIV_GLITCHLESS_UPDATE_EN
      shadow_q <= shadow_d;
`endif
    end
  end

  assign slow_clock = slow_q;
  assign tick       = tick_q;

endmodule

// File: rtl/multi_clock_divider.sv
// N_CH independent clock divider channels sharing clock, reset and sync restart.
// Macro CLKDIV_GLITCHLESS_UPDATE_EN selects period-start divisor sampling per channel.
module multi_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int N_CH  = CLKDIV_NCH_DEF,
  parameter int CNT_W = CLKDIV_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       en_i,
  input  logic                  sync_i,
  input  logic [N_CH*CNT_W-1:0] div_i,
  output logic [N_CH-1:0]       slow_clock,
  output logic [N_CH-1:0]       tick
);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    localparam int LSB = div_lsb(k, CNT_W);

    clkdiv_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en_i       (en_i[k]),
      .sync_i     (sync_i),
      .div_i      (div_i[LSB +: CNT_W]),
      .slow_clock (slow_clock[k]),
      .tick       (tick[k])
    );
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Self-checking bench for multi_clock_divider (2 channels, 4-bit counters).
// Honours CLKDIV_GLITCHLESS_UPDATE_EN for the divisor-update expectations.
module tb_multi_clock_divider;

  localparam int N_CH  = 2;
  localparam int CNT_W = 4;
  localparam int MODV  = 1 << CNT_W;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [N_CH-1:0]       en_i = '0;
  logic                  sync_i = 1'b0;
  logic [N_CH*CNT_W-1:0] div_i = '0;
  logic [N_CH-1:0]       slow_clock;
  logic [N_CH-1:0]       tick;

  int  n_pass = 0;
  int  n_total = 0;
  bit  chk_on = 1'b0;

  multi_clock_divider #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en_i       (en_i),
    .sync_i     (sync_i),
    .div_i      (div_i),
    .slow_clock (slow_clock),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: position within the current half period, measured in enabled cycles.
  int m_pos [N_CH];
  int m_len [N_CH];
  bit m_slow[N_CH];
  bit m_tick[N_CH];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) begin
        m_pos[k]  <= 0;
        m_len[k]  <= 0;
        m_slow[k] <= 1'b0;
        m_tick[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        int m, len, np;
        m   = int'(div_i[k*CNT_W +: CNT_W]);
        len = m_len[k];
        np  = m_pos[k];
        if (sync_i) begin
          m_pos[k]  <= 0;
          m_slow[k] <= 1'b0;
          m_tick[k] <= 1'b0;
        end else if (!en_i[k]) begin
          m_tick[k] <= 1'b0;
        end else begin
          m_tick[k] <= (m_pos[k] == 0);
          if (m_pos[k] == 0) m_slow[k] <= ~m_slow[k];
`ifdef CLKDIV_GLITCHLESS_UPDATE_EN
          // Half period length fixed at period start.
          if (m_pos[k] == 0) len = m;
          np = (m_pos[k] + 1) % (len + 1);
`else
          // Live divisor: half period ends when position meets it, else wraps modulo 2^W.
          np = (m_pos[k] == m) ? 0 : (m_pos[k] + 1) % MODV;
`endif
          m_pos[k] <= np;
          m_len[k] <= len;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < N_CH; k++) begin
        check($sformatf("model slow_clock[%0d]", k), int'(slow_clock[k]), int'(m_slow[k]));
        check($sformatf("model tick[%0d]", k), int'(tick[k]), int'(m_tick[k]));
      end
    end
  end

  task automatic edge_step();
    @(posedge clk);
    #2;
  endtask

  // Edges until tick[k] is seen (inclusive); -1 if the bound expires.
  task automatic edges_until_tick(input int k, input int max_e, output int n);
    n = -1;
    for (int i = 1; i <= max_e; i++) begin
      edge_step();
      if (tick[k]) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic set_div(input int k, input int v);
    div_i[k*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  initial begin
    int n, cnt;
    #1 rst = 1'b1;
    #1;
    check("reset slow_clock", int'(slow_clock), 0);
    check("reset tick", int'(tick), 0);
    chk_on = 1'b1;

    // div0=3 (period 8), div1=0 (period 2), released from reset.
    set_div(0, 3);
    set_div(1, 0);
    en_i = 2'b11;
    edge_step();
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      edge_step();
      if (e == 1) begin
        check("e1 slow0", int'(slow_clock[0]), 1);
        check("e1 tick0", int'(tick[0]), 1);
        check("e1 slow1", int'(slow_clock[1]), 1);
        check("e1 tick1", int'(tick[1]), 1);
      end
      if (e == 2) begin
        check("e2 tick0", int'(tick[0]), 0);
        check("e2 slow1", int'(slow_clock[1]), 0);
      end
      if (e == 4) check("e4 slow0", int'(slow_clock[0]), 1);
      if (e == 5) begin
        check("e5 slow0", int'(slow_clock[0]), 0);
        check("e5 tick0", int'(tick[0]), 1);
      end
      if (e == 9) check("e9 tick0", int'(tick[0]), 1);
    end

    // Asynchronous reset mid half-period.
    check("pre-reset slow0", int'(slow_clock[0]), 1);
    check("pre-reset tick1", int'(tick[1]), 1);
    rst = 1'b1;
    #1;
    check("async reset slow_clock", int'(slow_clock), 0);
    check("async reset tick", int'(tick), 0);
    set_div(1, 15);
    edge_step();
    rst = 1'b0;

    // Max divisor: ch1 toggles every 16 edges.
    cnt = 0;
    for (int e = 1; e <= 32; e++) begin
      edge_step();
      if (tick[1]) cnt++;
      if (e == 17) check("div15 e17 tick1", int'(tick[1]), 1);
    end
    check("div15 ticks in 32 edges", cnt, 2);

    // Enable pause on ch0 for 5 cycles.
    set_div(0, 3);
    sync_i = 1'b1;
    edge_step();
    sync_i = 1'b0;
    edges_until_tick(0, 4, n);
    check("pause first tick", n, 1);
    edge_step();
    en_i[0] = 1'b0;
    cnt = 0;
    for (int e = 0; e < 5; e++) begin
      edge_step();
      if (tick[0]) cnt++;
    end
    check("pause ticks", cnt, 0);
    check("pause slow0 held", int'(slow_clock[0]), 1);
    en_i[0] = 1'b1;
    edges_until_tick(0, 12, n);
    check("pause lengthened", n, 3);

    // Sync alignment from arbitrary phases.
    set_div(0, 2);
    set_div(1, 5);
    repeat ($urandom_range(3, 11)) edge_step();
    sync_i = 1'b1;
    edge_step();
    sync_i = 1'b0;
    check("sync slow_clock", int'(slow_clock), 0);
    check("sync tick", int'(tick), 0);
    edge_step();
    check("post-sync slow_clock", int'(slow_clock), 3);
    check("post-sync tick", int'(tick), 3);

    // Divisor change 7 -> 1 once ch0 count reaches 4.
    set_div(0, 7);
    sync_i = 1'b1;
    edge_step();
    sync_i = 1'b0;
    edges_until_tick(0, 4, n);
    check("divchg first tick", n, 1);
    repeat (3) edge_step();
    set_div(0, 1);
    edges_until_tick(0, 40, n);
`ifdef CLKDIV_GLITCHLESS_UPDATE_EN
    check("divchg current half", n, 5);
`else
    check("divchg wrap half", n, 13);
`endif
    edges_until_tick(0, 10, n);
    check("divchg next half", n, 2);
    repeat (6) edge_step();

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
